text_buffer: RTL and testbench

//  Character RAM for the serial-LCD text screen; supplies the character code for the tile currently rasterised.

---
 rtl/text_buffer_pkg.sv | 19 +
 rtl/text_buffer_if.sv | 15 +
 rtl/text_buffer_ram.sv | 33 +++
 rtl/text_buffer.sv | 186 ++++++++++++++++++
 tb/tb_text_buffer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_buffer_pkg.sv
// text_buffer_pkg: shared constants and state encoding for the text_buffer slice.
//   - control-code values interpreted by the character writer
//   - t_tb_state: FSM state encoding (CLEAR_ALL, IDLE, CLEAR_ROW)
package text_buffer_pkg;

    localparam int CHR_LF        = 'h0A;
    localparam int CHR_CR        = 'h0D;
    localparam int CHR_BS        = 'h08;
    localparam int CHR_FF        = 'h0C;
    localparam int CHR_PRINT_MIN = 'h20;
    localparam int CHR_PRINT_MAX = 'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } t_tb_state;

endpackage

// File: rtl/text_buffer_if.sv
// text_buffer_if: character write stream (valid/ready) into the text buffer.
//   in_char         character code from the writer
//   in_char_valid   in_char valid, held until accepted
//   out_char_ready  buffer accepts in_char this cycle
// Modports: master = character source, slave = text_buffer.
interface text_buffer_if #(
    parameter int CHAR_BITS = 7
) ();
    logic [CHAR_BITS-1:0] in_char;
    logic                 in_char_valid;
    logic                 out_char_ready;

    modport master (output in_char, output in_char_valid, input  out_char_ready);
    modport slave  (input  in_char, input  in_char_valid, output out_char_ready);
endinterface

// File: rtl/text_buffer_ram.sv
// text_buffer_ram: simple dual-port character RAM, one write port and one
// registered read port, read-first on same-address collisions.
//   clk, rst        clock; rst only initialises the read register to FILL
//   we/waddr/wdata  write port
//   raddr/rdata     read port, rdata valid one cycle after raddr
// Out-of-range read addresses return FILL.
module text_buffer_ram #(
    parameter int             DEPTH = 240,
    parameter int             AW    = 8,
    parameter int             DW    = 7,
    parameter logic [DW-1:0]  FILL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Non-blocking read of mem gives the pre-write value on a collision.
    always_ff @(posedge clk) begin
        if (rst)                    rdata <= FILL;
        else if (raddr < AW'(DEPTH)) rdata <= mem[raddr];
        else                        rdata <= FILL;
    end
endmodule

// File: rtl/text_buffer.sv
// text_buffer: character RAM for the serial-LCD text screen.
// Write side takes a cursor-driven character stream (printables, LF, CR, BS,
// FF); read side maps tile (x,y) to the stored char with one-cycle latency.
// Ports:
//   in_clk, in_rst          clock, synchronous active-high reset
//   wr (text_buffer_if)     in_char / in_char_valid / out_char_ready
//   in_tile_x, in_tile_y    read tile coordinates
//   out_char                char at tile, registered
//   out_cursor_x/_y         current cursor (logical row)
//   out_busy                a clear is in progress
// Build option: TEXT_BUFFER_SCROLL_EN -- newline on the last row scrolls the
// screen (row offset advances); otherwise the cursor wraps to row 0.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int                   COLS      = 30,
    parameter int                   ROWS      = 8,
    parameter int                   CHAR_BITS = 7,
    parameter logic [CHAR_BITS-1:0] FILL_CHAR = 7'h20
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    text_buffer_if.slave              wr,
    input  logic [$clog2(COLS)-1:0]   in_tile_x,
    input  logic [$clog2(ROWS)-1:0]   in_tile_y,
    output logic [CHAR_BITS-1:0]      out_char,
    output logic [$clog2(COLS)-1:0]   out_cursor_x,
    output logic [$clog2(ROWS)-1:0]   out_cursor_y,
    output logic                      out_busy
);
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [1:0] S_CLEAR_ALL = CLEAR_ALL;
    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_CLEAR_ROW = CLEAR_ROW;

    localparam logic [YW:0]   ROWS_W   = (YW+1)'(ROWS);
    localparam logic [AW-1:0] LAST_ALL = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(COLS - 1);

    logic [1:0]    state;
    logic [AW-1:0] cnt;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [YW-1:0] offset;
    logic [YW-1:0] clr_row;

    // Logical row -> physical row by compare-and-subtract, then linear address.
    function automatic logic [AW-1:0] map_addr(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y,
                                               input logic [YW-1:0] off);
        logic [YW:0] row;
        row = {1'b0, y} + {1'b0, off};
        if (row >= ROWS_W) row = row - ROWS_W;
        return AW'(row) * AW'(COLS) + AW'(x);
    endfunction

    logic xfer, is_print, is_lf, is_cr, is_bs, is_ff, x_last, y_last, nl;

    always_comb begin
        wr.out_char_ready = (state == S_IDLE) && !in_rst;
        xfer     = wr.in_char_valid && wr.out_char_ready;
        is_print = (wr.in_char >= CHAR_BITS'(CHR_PRINT_MIN)) &&
                   (wr.in_char <= CHAR_BITS'(CHR_PRINT_MAX));
        is_lf    = (wr.in_char == CHAR_BITS'(CHR_LF));
        is_cr    = (wr.in_char == CHAR_BITS'(CHR_CR));
        is_bs    = (wr.in_char == CHAR_BITS'(CHR_BS));
        is_ff    = (wr.in_char == CHAR_BITS'(CHR_FF));
        x_last   = (cur_x == XW'(COLS - 1));
        y_last   = (cur_y == YW'(ROWS - 1));
        nl       = xfer && ((is_print && x_last) || is_lf);
    end

    // Write port: clears own the RAM outside IDLE; IDLE writes printables.
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [CHAR_BITS-1:0] wdata;

    always_comb begin
        we    = 1'b0;
        waddr = cnt;
        wdata = FILL_CHAR;
        case (state)
            S_CLEAR_ALL: we = 1'b1;
            S_CLEAR_ROW: begin
                we    = 1'b1;
                waddr = AW'(clr_row) * AW'(COLS) + cnt;
            end
            S_IDLE: begin
                if (xfer && is_print) begin
                    we    = 1'b1;
                    waddr = map_addr(cur_x, cur_y, offset);
                    wdata = wr.in_char;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state   <= S_CLEAR_ALL;
            cnt     <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            offset  <= '0;
            clr_row <= '0;
        end else begin
            case (state)
                S_CLEAR_ALL: begin
                    if (cnt == LAST_ALL) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CLEAR_ROW: begin
                    if (cnt == LAST_ROW) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (xfer && is_ff) begin
                        cur_x  <= '0;
                        cur_y  <= '0;
                        offset <= '0;
                        state  <= S_CLEAR_ALL;
                        cnt    <= '0;
                    end else if (xfer) begin
                        if (is_print)                  cur_x <= x_last ? '0 : cur_x + 1'b1;
                        else if (is_lf || is_cr)       cur_x <= '0;
                        else if (is_bs && cur_x != '0) cur_x <= cur_x - 1'b1;

                        if (nl) begin
                            if (!y_last) begin
                                cur_y <= cur_y + 1'b1;
                            end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
                                // Old top physical row becomes the new bottom row.
                                offset  <= (offset == YW'(ROWS - 1)) ? '0 : offset + 1'b1;
                                clr_row <= offset;
`else
                                cur_y   <= '0;
                                clr_row <= '0;
`endif
                                state <= S_CLEAR_ROW;
                                cnt   <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_CLEAR_ALL;
                    cnt   <= '0;
                end
            endcase
        end
    end

    text_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (CHAR_BITS),
        .FILL  (FILL_CHAR)
    ) u_ram (
        .clk   (in_clk),
        .rst   (in_rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (map_addr(in_tile_x, in_tile_y, offset)),
        .rdata (out_char)
    );

    assign out_cursor_x = cur_x;
    assign out_cursor_y = cur_y;
    assign out_busy     = (state != S_IDLE) || in_rst;

endmodule

// File: tb/tb_text_buffer.sv
module tb_text_buffer;
    localparam int COLS = 30;
    localparam int ROWS = 8;

    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    always #5 in_clk = ~in_clk;

    text_buffer_if #(.CHAR_BITS(7)) wr_if ();
    logic [4:0] tile_x = '0;
    logic [2:0] tile_y = '0;
    logic [6:0] out_char;
    logic [4:0] cur_x_o;
    logic [2:0] cur_y_o;
    logic       busy;

    text_buffer dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .wr           (wr_if),
        .in_tile_x    (tile_x),
        .in_tile_y    (tile_y),
        .out_char     (out_char),
        .out_cursor_x (cur_x_o),
        .out_cursor_y (cur_y_o),
        .out_busy     (busy)
    );

    int n_cmp = 0, n_bad = 0;
    int n_sent = 0, n_xfer = 0;

    // Reference: the screen as the viewer sees it, indexed by logical row.
    logic [6:0] scr [ROWS][COLS];
    int mx, my, exp_busy;

    logic [6:0] exp_q [$];
    logic       rd_req = 1'b0, rd_vld = 1'b0;
    logic [6:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: one read result per requested tile, one cycle later.
    always @(posedge in_clk) begin
        rd_vld <= rd_req;
        if (wr_if.in_char_valid && wr_if.out_char_ready) n_xfer <= n_xfer + 1;
    end

    always @(negedge in_clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) check("rd_underflow", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("rd_char", {25'd0, out_char}, {25'd0, mon_e});
            end
        end
    end

    task automatic m_clear_row(input int r);
        for (int c = 0; c < COLS; c++) scr[r][c] = 7'h20;
    endtask

    task automatic m_reset();
        for (int r = 0; r < ROWS; r++) m_clear_row(r);
        mx = 0; my = 0;
    endtask

    task automatic m_newline();
        if (my < ROWS - 1) my++;
        else begin
`ifdef TEXT_BUFFER_SCROLL_EN
            for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r+1];
            m_clear_row(ROWS - 1);
`else
            my = 0;
            m_clear_row(0);
`endif
            exp_busy = COLS;
        end
    endtask

    task automatic m_char(input logic [6:0] c);
        exp_busy = 0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            scr[my][mx] = c;
            if (mx == COLS - 1) begin mx = 0; m_newline(); end
            else mx++;
        end else if (c == 7'h0A) begin
            mx = 0; m_newline();
        end else if (c == 7'h0D) begin
            mx = 0;
        end else if (c == 7'h08) begin
            if (mx > 0) mx--;
        end else if (c == 7'h0C) begin
            m_reset();
            exp_busy = COLS * ROWS;
        end
    endtask

    // Transfer one char; optionally read the cursor cell on the write edge.
    task automatic send(input logic [6:0] c, input bit rd_same);
        int t = 0;
        @(negedge in_clk);
        wr_if.in_char = c;
        wr_if.in_char_valid = 1'b1;
        while (!wr_if.out_char_ready && t < 1000) begin @(negedge in_clk); t++; end
        if (t >= 1000) begin
            check("send_timeout", 0, 1);
            wr_if.in_char_valid = 1'b0;
            return;
        end
        if (rd_same) begin
            tile_x = 5'(mx); tile_y = 3'(my);
            exp_q.push_back(scr[my][mx]);
            rd_req = 1'b1;
        end
        @(posedge in_clk);
        #1;
        wr_if.in_char_valid = 1'b0;
        rd_req = 1'b0;
        n_sent++;
        m_char(c);
        check("cursor_x", {27'd0, cur_x_o}, mx);
        check("cursor_y", {29'd0, cur_y_o}, my);
    endtask

    // Called on a negedge; counts negedges with ready low.
    task automatic measure(input int exp);
        int lo = 0, bz = 0;
        while (!wr_if.out_char_ready && lo < 1000) begin
            if (busy) bz++;
            lo++;
            @(negedge in_clk);
        end
        check("ready_low_cycles", lo, exp);
        check("busy_cycles", bz, exp);
        check("busy_idle", {31'd0, busy}, 0);
    endtask

    task automatic sendc(input logic [6:0] c);
        send(c, 1'b0);
        @(negedge in_clk);
        measure(exp_busy);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) sendc(7'(s[i]));
    endtask

    task automatic scan();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                @(negedge in_clk);
                tile_x = 5'(x); tile_y = 3'(y);
                exp_q.push_back(scr[y][x]);
                rd_req = 1'b1;
            end
        @(negedge in_clk);
        rd_req = 1'b0;
        @(negedge in_clk);
    endtask

    task automatic rand_char(output logic [6:0] c);
        int r = $urandom_range(0, 99);
        if (r < 62)      c = 7'($urandom_range(32'h20, 32'h7E));
        else if (r < 74) c = 7'h0A;
        else if (r < 80) c = 7'h0D;
        else if (r < 90) c = 7'h08;
        else if (r < 99) begin
            case ($urandom_range(0, 3))
                0: c = 7'h00;
                1: c = 7'h07;
                2: c = 7'h1B;
                default: c = 7'h7F;
            endcase
        end else c = 7'h0C;
    endtask

    initial begin
        logic [6:0] c;
        wr_if.in_char = '0;
        wr_if.in_char_valid = 1'b0;
        m_reset();

        // Reset state
        repeat (3) @(negedge in_clk);
        check("rst_ready", {31'd0, wr_if.out_char_ready}, 0);
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_out_char", {25'd0, out_char}, 32'h20);
        check("rst_cursor_x", {27'd0, cur_x_o}, 0);
        check("rst_cursor_y", {29'd0, cur_y_o}, 0);
        in_rst = 1'b0;
        measure(COLS * ROWS);
        scan();

        // Single char, with a same-cycle read of the written cell (old value)
        send(7'h41, 1'b1);
        @(negedge in_clk);
        measure(exp_busy);
        scan();

        // Line wrap without a clear
        for (int i = 0; i < COLS; i++) sendc(7'h42);
        scan();

        // Fill every row, final LF hits the last row
        sendc(7'h0C);
        for (int i = 0; i < ROWS; i++) begin
            string s;
            s = $sformatf("L%0d\n", i);
            send_str(s);
        end
        scan();

        // BS at column 0, ignored control code, form feed
        sendc(7'h0C);
        sendc(7'h08);
        sendc(7'h07);
        send_str("Hi\x08\x08\x08\rX");
        scan();
        sendc(7'h0C);
        scan();

        // Randomized stream
        for (int i = 0; i < 250; i++) begin
            rand_char(c);
            sendc(c);
        end
        scan();

        // Reset 100 cycles into a full clear with valid already held
        send(7'h0C, 1'b0);
        repeat (100) @(negedge in_clk);
        in_rst = 1'b1;
        wr_if.in_char = 7'h5A;
        wr_if.in_char_valid = 1'b1;
        @(negedge in_clk);
        in_rst = 1'b0;
        m_reset();
        measure(COLS * ROWS);
        @(posedge in_clk);
        #1;
        wr_if.in_char_valid = 1'b0;
        n_sent++;
        m_char(7'h5A);
        check("held_cursor_x", {27'd0, cur_x_o}, mx);
        check("held_cursor_y", {29'd0, cur_y_o}, my);
        repeat (3) @(negedge in_clk);
        scan();

        check("xfer_count", n_xfer, n_sent);
        check("rd_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
